// File: rtl/id_ex_pipe_reg.sv
// Decode->Execute pipeline register: stall/flush bubbles, valid bit, control-field X-scrubbing.
// Define ID_EX_PERF_EN to add the saturating InstrCnt/BubbleCnt occupancy counters.
module id_ex_pipe_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            ValidD,
    input  logic            RegWriteD,
    input  logic [1:0]      ResultSrcD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic [2:0]      ALUControlD,
    input  logic            ALUSrcD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    output logic            ValidE,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic [2:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE
`ifdef ID_EX_PERF_EN
    ,
    output logic [CNT_W-1:0] InstrCnt,
    output logic [CNT_W-1:0] BubbleCnt
`endif
);

    logic            valid_q,     valid_d;
    logic            reg_write_q, reg_write_d;
    logic [1:0]      result_src_q, result_src_d;
    logic            mem_write_q, mem_write_d;
    logic            jump_q,      jump_d;
    logic            branch_q,    branch_d;
    logic [2:0]      alu_ctrl_q,  alu_ctrl_d;
    logic            alu_src_q,   alu_src_d;
    logic [XLEN-1:0] rd1_q,       rd1_d;
    logic [XLEN-1:0] rd2_q,       rd2_d;
    logic [XLEN-1:0] pc_q,        pc_d;
    logic [XLEN-1:0] pc_plus4_q,  pc_plus4_d;
    logic [XLEN-1:0] imm_ext_q,   imm_ext_d;
    logic [4:0]      rs1_q,       rs1_d;
    logic [4:0]      rs2_q,       rs2_d;
    logic [4:0]      rd_q,        rd_d;

    logic capture;
    assign capture = !FlushE && !StallE;

    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        result_src_d = result_src_q;
        mem_write_d  = mem_write_q;
        jump_d       = jump_q;
        branch_d     = branch_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_src_d    = alu_src_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        pc_d         = pc_q;
        pc_plus4_d   = pc_plus4_q;
        imm_ext_d    = imm_ext_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        if (FlushE) begin
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            result_src_d = 2'b00;
            mem_write_d  = 1'b0;
            jump_d       = 1'b0;
            branch_d     = 1'b0;
            alu_ctrl_d   = 3'b000;
            alu_src_d    = 1'b0;
            rd1_d        = '0;
            rd2_d        = '0;
            pc_d         = '0;
            pc_plus4_d   = '0;
            imm_ext_d    = '0;
            rs1_d        = '0;
            rs2_d        = '0;
            rd_d         = '0;
        end else if (!StallE) begin
            valid_d    = ValidD;
            rd1_d      = RD1D;
            rd2_d      = RD2D;
            pc_d       = PCD;
            pc_plus4_d = PCPlus4D;
            imm_ext_d  = ImmExtD;
            rs1_d      = Rs1D;
            rs2_d      = Rs2D;
            rd_d       = RdD;
            // Fields the control unit leaves as don't-care are forced to 0 so E never sees X.
            reg_write_d  = ValidD & RegWriteD;
            result_src_d = (ValidD && RegWriteD) ? ResultSrcD : 2'b00;
            mem_write_d  = ValidD & MemWriteD;
            jump_d       = ValidD & JumpD;
            branch_d     = ValidD & BranchD;
            alu_ctrl_d   = (ValidD && !JumpD) ? ALUControlD : 3'b000;
            alu_src_d    = ValidD & !JumpD & ALUSrcD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            mem_write_q  <= 1'b0;
            jump_q       <= 1'b0;
            branch_q     <= 1'b0;
            alu_ctrl_q   <= 3'b000;
            alu_src_q    <= 1'b0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            pc_q         <= '0;
            pc_plus4_q   <= '0;
            imm_ext_q    <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            mem_write_q  <= mem_write_d;
            jump_q       <= jump_d;
            branch_q     <= branch_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_src_q    <= alu_src_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            pc_q         <= pc_d;
            pc_plus4_q   <= pc_plus4_d;
            imm_ext_q    <= imm_ext_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
        end
    end

    assign ValidE      = valid_q;
    assign RegWriteE   = reg_write_q;
    assign ResultSrcE  = result_src_q;
    assign MemWriteE   = mem_write_q;
    assign JumpE       = jump_q;
    assign BranchE     = branch_q;
    assign ALUControlE = alu_ctrl_q;
    assign ALUSrcE     = alu_src_q;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign PCE         = pc_q;
    assign PCPlus4E    = pc_plus4_q;
    assign ImmExtE     = imm_ext_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;
    assign RdE         = rd_q;

`ifdef ID_EX_PERF_EN
    logic [CNT_W-1:0] instr_cnt_q,  instr_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    always_comb begin
        instr_cnt_d  = instr_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (capture && ValidD)
            instr_cnt_d = sat_inc(instr_cnt_q);
        if (FlushE || (capture && !ValidD))
            bubble_cnt_d = sat_inc(bubble_cnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            instr_cnt_q  <= instr_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign InstrCnt  = instr_cnt_q;
    assign BubbleCnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: per-cycle reference model plus directed literal checks.
// Counter checks are active when ID_EX_PERF_EN is defined.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic        j;
        logic        b;
        logic [2:0]  alu;
        logic        as;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } stage_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   StallE = 1'b0;
    logic   FlushE = 1'b0;
    stage_t din = '0;
    stage_t act;
    stage_t exp_e = '0;
    int     exp_ic = 0;
    int     exp_bc = 0;
    int     n_cmp = 0;
    int     n_fail = 0;

    logic            ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE;
    logic [31:0]     RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]      Rs1E, Rs2E, RdE;
`ifdef ID_EX_PERF_EN
    logic [3:0]      InstrCnt, BubbleCnt;
`endif

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
        .ValidD(din.v), .RegWriteD(din.rw), .ResultSrcD(din.rs), .MemWriteD(din.mw),
        .JumpD(din.j), .BranchD(din.b), .ALUControlD(din.alu), .ALUSrcD(din.as),
        .RD1D(din.rd1), .RD2D(din.rd2), .PCD(din.pc), .PCPlus4D(din.pc4),
        .ImmExtD(din.imm), .Rs1D(din.rs1), .Rs2D(din.rs2), .RdD(din.rd),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
`ifdef ID_EX_PERF_EN
        , .InstrCnt(InstrCnt), .BubbleCnt(BubbleCnt)
`endif
    );

    assign act = '{v: ValidE, rw: RegWriteE, rs: ResultSrcE, mw: MemWriteE, j: JumpE,
                   b: BranchE, alu: ALUControlE, as: ALUSrcE, rd1: RD1E, rd2: RD2E,
                   pc: PCE, pc4: PCPlus4E, imm: ImmExtE, rs1: Rs1E, rs2: Rs2E, rd: RdE};

    // Reference: what E must contain after an edge, stated from the stage rules.
    function automatic stage_t next_e(stage_t cur, stage_t d, logic stall, logic flush);
        stage_t n;
        if (flush) return '0;
        if (stall) return cur;
        n = d;
        if (!d.v) begin
            n.rw = 0; n.rs = 0; n.mw = 0; n.j = 0; n.b = 0; n.alu = 0; n.as = 0;
        end else begin
            if (!d.rw) n.rs = 2'b00;
            if (d.j) begin n.alu = 3'b000; n.as = 1'b0; end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_e  <= '0;
            exp_ic <= 0;
            exp_bc <= 0;
        end else begin
            exp_e <= next_e(exp_e, din, StallE, FlushE);
            if (!FlushE && !StallE && din.v && exp_ic < 15) exp_ic <= exp_ic + 1;
            if ((FlushE || (!StallE && !din.v)) && exp_bc < 15) exp_bc <= exp_bc + 1;
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if (act !== exp_e) begin
            n_fail++;
            $display("FAIL e_stage t=%0t actual=%h required=%h", $time, act, exp_e);
        end
`ifdef ID_EX_PERF_EN
        n_cmp++;
        if (InstrCnt !== 4'(exp_ic) || BubbleCnt !== 4'(exp_bc)) begin
            n_fail++;
            $display("FAIL perf_cnt t=%0t actual=%0d/%0d required=%0d/%0d",
                     $time, InstrCnt, BubbleCnt, exp_ic, exp_bc);
        end
`endif
    end

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                         input logic j, input logic b, input logic [2:0] alu, input logic as,
                         input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd);
        din = '{v: v, rw: rw, rs: rs, mw: mw, j: j, b: b, alu: alu, as: as, rd1: rd1,
                rd2: rd2, pc: pc, pc4: pc + 32'd4, imm: imm, rs1: rs1, rs2: rs2, rd: rd};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        chk("reset_valid", ValidE, 0);
        chk("reset_all", act, 0);
        rst_n = 1'b1;

        // R-type add x3 = x1 + x2
        set_d(1, 1, 2'b00, 0, 0, 0, 3'b000, 0, 5, 7, 32'h100, 0, 1, 2, 3);
        tick();
        chk("add_regwrite", RegWriteE, 1);
        chk("add_aluctl", ALUControlE, 0);
        chk("add_rd1", RD1E, 5);
        chk("add_rd2", RD2E, 7);
        chk("add_rd", RdE, 3);
        chk("add_valid", ValidE, 1);
        chk("add_pc4", PCPlus4E, 32'h104);

        // sw: ResultSrcD is garbage since RegWriteD=0
        set_d(1, 0, 2'b11, 1, 0, 0, 3'b000, 1, 32'h200, 32'hAB, 32'h104, 8, 4, 5, 0);
        tick();
        chk("sw_resultsrc", ResultSrcE, 0);
        chk("sw_memwrite", MemWriteE, 1);
        chk("sw_alusrc", ALUSrcE, 1);

        // jal: ALUSrcD/ALUControlD are garbage
        set_d(1, 1, 2'b10, 0, 1, 0, 3'b111, 1, 0, 0, 32'h108, 32'h40, 0, 0, 1);
        tick();
        chk("jal_alusrc", ALUSrcE, 0);
        chk("jal_jump", JumpE, 1);
        chk("jal_resultsrc", ResultSrcE, 2'b10);
        chk("jal_aluctl", ALUControlE, 0);

        // lw x9, 4(x8), then stall three cycles while D keeps changing
        set_d(1, 1, 2'b01, 0, 0, 0, 3'b000, 1, 32'h40, 0, 32'h10C, 4, 8, 0, 9);
        tick();
        chk("lw_rd", RdE, 9);
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_d(1, 1, 2'b00, 1, 0, 1, 3'b010, 0, $urandom, $urandom, $urandom, $urandom,
                  5'd20, 5'd21, 5'(i + 22));
            tick();
            chk("stall_rd", RdE, 9);
            chk("stall_rd1", RD1E, 32'h40);
            chk("stall_rsrc", ResultSrcE, 2'b01);
        end
        FlushE = 1'b1;
        tick();
        chk("flush_valid", ValidE, 0);
        chk("flush_regwrite", RegWriteE, 0);
        chk("flush_rd1", RD1E, 0);
        StallE = 1'b0;
        FlushE = 1'b0;

        // Invalid slot: control unit still asserts controls, data still captured
        set_d(0, 1, 2'b01, 1, 1, 1, 3'b011, 1, 32'h55, 32'h66, 32'h200, 0, 1, 2, 3);
        tick();
        chk("inv_regwrite", RegWriteE, 0);
        chk("inv_valid", ValidE, 0);
        chk("inv_memwrite", MemWriteE, 0);
        chk("inv_rd1", RD1E, 32'h55);

        // Mixed traffic, checked by the per-cycle model
        for (int i = 0; i < 40; i++) begin
            din = stage_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            StallE = ($urandom_range(0, 3) == 0);
            FlushE = ($urandom_range(0, 5) == 0);
            tick();
        end
        StallE = 1'b0;
        FlushE = 1'b0;

        // Async reset mid-cycle with all-ones inputs, then release mid-stream
        din = '1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_all", act, 0);
        chk("async_rst_rd1", RD1E, 0);
        tick();
        chk("rst_hold", act, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", ValidE, 1);
        chk("post_rst_rd1", RD1E, 32'hFFFF_FFFF);
        chk("post_rst_aluctl", ALUControlE, 0);
        chk("post_rst_rsrc", ResultSrcE, 2'b11);

`ifdef ID_EX_PERF_EN
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        set_d(1, 1, 2'b00, 0, 0, 0, 3'b000, 0, 1, 2, 32'h300, 0, 1, 2, 3);
        for (int i = 0; i < 20; i++) tick();
        chk("instr_sat", InstrCnt, 15);
        chk("bubble_zero", BubbleCnt, 0);
        FlushE = 1'b1;
        repeat (2) tick();
        FlushE = 1'b0;
        StallE = 1'b1;
        repeat (3) tick();
        StallE = 1'b0;
        chk("bubble_two", BubbleCnt, 2);
        chk("instr_held", InstrCnt, 15);
        #2 rst_n = 1'b0;
        #1;
        chk("perf_rst_instr", InstrCnt, 0);
        chk("perf_rst_bubble", BubbleCnt, 0);
        rst_n = 1'b1;
        tick();
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
